s420_brm: RTL

Parametrised, clocked binary rate multiplier (BRM) for the s420 benchmark family. A shared WIDTH-bit up-counter advances on input X. Each of CHANNELS outputs emits exactly C pulses per 2^WIDTH advances, where C is that channel's rate word. Rate words are loaded through a valid/ready handshake and take effect only at a counter period boundary, so every period is glitch-free. The block sits beside the combinational s420 netlists as the sequential, multi-channel, reconfigurable reference for equivalence and fault-simulation runs.

---
 rtl/s420_brm.sv | 99 +++++++++
 1 files changed

// File: rtl/s420_brm.sv
// Multi-channel binary rate multiplier: one shared up-counter, per-channel rate
// words loaded via valid/ready and committed only at period boundaries.
module s420_brm #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                CK,
    input  logic                reset,
    input  logic                clear,
    input  logic                X,
    input  logic                rate_valid,
    output logic                rate_ready,
    input  logic [CHW-1:0]      rate_ch,
    input  logic [WIDTH-1:0]    rate_data,
    output logic [CHANNELS-1:0] Z,
    output logic                W,
    output logic [WIDTH-1:0]    Y
);

    logic [WIDTH-1:0]    r_y;
    logic [CHANNELS-1:0] r_z;
    logic                r_w;
    logic                r_pending;
    logic [WIDTH-1:0]    r_shadow_data;
    logic [CHW-1:0]      r_shadow_ch;
    logic [WIDTH-1:0]    r_rate [CHANNELS];

    logic                w_adv;
    logic                w_wrap;
    logic                w_xfer;
    logic                w_commit;
    logic [WIDTH-1:0]    w_y_inc;
    logic [WIDTH-1:0]    w_rise;
    logic [CHANNELS-1:0] w_pulse;

    // Handshake: a word transfers on any rising edge where rate_valid and
    // rate_ready are both high; the producer holds valid and data until then.
    // Only one word can wait in the shadow register, so ready = ~pending.
    assign rate_ready = ~r_pending;
    assign w_xfer     = rate_valid & ~r_pending;

    assign w_adv    = X & ~clear;
    assign w_wrap   = w_adv & (&r_y);
    assign w_commit = r_pending & (w_wrap | clear);
    assign w_y_inc  = r_y + WIDTH'(1);

    // One-hot of the bit that goes 0->1 on this increment; zero when Y is all ones.
    assign w_rise = ~r_y & w_y_inc;

    always_comb begin
        w_pulse = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int b = 0; b < WIDTH; b++) begin
                w_pulse[c] = w_pulse[c] | (w_rise[b] & r_rate[c][WIDTH-1-b]);
            end
        end
    end

    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            r_y           <= '0;
            r_z           <= '0;
            r_w           <= 1'b0;
            r_pending     <= 1'b0;
            r_shadow_data <= '0;
            r_shadow_ch   <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_rate[c] <= '0;
            end
        end else begin
            if (clear) begin
                r_y <= '0;
            end else if (X) begin
                r_y <= w_y_inc;
            end
            r_z <= w_adv ? w_pulse : '0;
            r_w <= w_wrap;
            if (w_xfer) begin
                r_shadow_data <= rate_data;
                r_shadow_ch   <= rate_ch;
                r_pending     <= 1'b1;
            end else if (w_commit) begin
                // An out-of-range channel matches nothing, so the word is dropped.
                for (int c = 0; c < CHANNELS; c++) begin
                    if (r_shadow_ch == CHW'(c)) begin
                        r_rate[c] <= r_shadow_data;
                    end
                end
                r_pending <= 1'b0;
            end
        end
    end

    assign Z = r_z;
    assign W = r_w;
    assign Y = r_y;

endmodule
